// File: rtl/mem_access_sequencer.sv
// Data-memory access sequencer for the MEM stage.
// Turns the EX/MEM load/store flags into a single handshaked memory request,
// stalls the pipeline while the access is in flight, and reports completion,
// timeout and misalignment. All state advances on the falling clock edge.
module mem_access_sequencer #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        err_clr_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        wb_valid_o,
    output logic        err_o
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE,
        ABORT
    } state_t;

    state_t          state;
    state_t          next_state;
    logic            access;
    logic            aligned;
    logic            accept;
    logic            err_event;
    logic            timed_out;
    logic [CW-1:0]   cycle_cnt;

    // Next-state decode, access acceptance, error events and the combinational stall.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        err_event  = 1'b0;
        access     = mem_read_i | mem_write_i;
        aligned    = (addr_i[1:0] == 2'b00);
        timed_out  = (cycle_cnt == CW'(TIMEOUT - 1));
        case (state)
            IDLE: begin
                if (access) begin
                    if (aligned) begin
                        accept     = 1'b1;
                        next_state = BUSY;
                    end else begin
                        err_event  = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (mem_ack_i) begin
                    next_state = DONE;
                end else if (timed_out) begin
                    next_state = ABORT;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            ABORT: begin
                next_state = IDLE;
                err_event  = 1'b1;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        stall_o = reset & ((state == IDLE && access && aligned) || state == BUSY);
    end

    // State register; reset returns to IDLE immediately.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Latches the accepted access, runs the busy-cycle counter and captures load data.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            mem_we_o    <= 1'b0;
            mem_addr_o  <= 32'h0;
            mem_wdata_o <= 32'h0;
            rdata_o     <= 32'h0;
            cycle_cnt   <= '0;
        end else if (accept) begin
            mem_we_o    <= mem_write_i;
            mem_addr_o  <= addr_i;
            mem_wdata_o <= wdata_i;
            cycle_cnt   <= '0;
        end else if (state == BUSY) begin
            cycle_cnt <= cycle_cnt + 1'b1;
            if (mem_ack_i && !mem_we_o) begin
                rdata_o <= mem_rdata_i;
            end
        end
    end

    // Registered request, completion pulse and sticky error flag.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            mem_req_o  <= 1'b0;
            wb_valid_o <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            mem_req_o  <= (next_state == BUSY);
            wb_valid_o <= (state == BUSY) && mem_ack_i;
            if (err_event) begin
                err_o <= 1'b1;
            end else if (err_clr_i) begin
                err_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Self-checking bench for mem_access_sequencer: a transaction-level model
// checked every cycle, plus directed scenarios with hand-computed results.
module tb_mem_access_sequencer;

    localparam int TIMEOUT = 16;

    logic        clk;
    logic        reset;
    logic        mem_read_i;
    logic        mem_write_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        err_clr_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] rdata_o;
    logic        stall_o;
    logic        wb_valid_o;
    logic        err_o;

    int tests = 0;
    int fails = 0;

    mem_access_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_read_i (mem_read_i),
        .mem_write_i(mem_write_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .mem_ack_i  (mem_ack_i),
        .mem_rdata_i(mem_rdata_i),
        .err_clr_i  (err_clr_i),
        .mem_req_o  (mem_req_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .rdata_o    (rdata_o),
        .stall_o    (stall_o),
        .wb_valid_o (wb_valid_o),
        .err_o      (err_o)
    );

    // Free-running clock; the design acts on falling edges.
    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Transaction-level model: an access in flight, its elapsed cycles, and the
    // one-cycle outcome (0 none, 1 completed, 2 aborted) that follows it.
    bit          m_active = 0;
    int          m_cycles = 0;
    int          m_post   = 0;
    bit          m_we     = 0;
    logic [31:0] m_addr   = 0;
    logic [31:0] m_wdata  = 0;
    logic [31:0] m_rdata  = 0;
    bit          m_err    = 0;

    always @(negedge clk or negedge reset) begin
        bit err_event;
        if (!reset) begin
            m_active = 0; m_cycles = 0; m_post = 0; m_we = 0;
            m_addr = 0; m_wdata = 0; m_rdata = 0; m_err = 0;
        end else begin
            err_event = 0;
            if (m_post != 0) begin
                if (m_post == 2) err_event = 1;
                m_post = 0;
            end else if (m_active) begin
                m_cycles++;
                if (mem_ack_i) begin
                    if (!m_we) m_rdata = mem_rdata_i;
                    m_active = 0;
                    m_post   = 1;
                end else if (m_cycles == TIMEOUT) begin
                    m_active = 0;
                    m_post   = 2;
                end
            end else if (mem_read_i || mem_write_i) begin
                if (addr_i % 4 == 0) begin
                    m_active = 1;
                    m_cycles = 0;
                    m_addr   = addr_i;
                    m_wdata  = wdata_i;
                    m_we     = mem_write_i;
                end else begin
                    err_event = 1;
                end
            end
            if (err_event) m_err = 1;
            else if (err_clr_i) m_err = 0;
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    always @(posedge clk) begin
        bit exp_stall;
        exp_stall = reset && (m_active ||
                    (m_post == 0 && (mem_read_i || mem_write_i) && addr_i % 4 == 0));
        checkOutput("mem_req", mem_req_o, m_active);
        checkOutput("wb_valid", wb_valid_o, m_post == 1);
        checkOutput("stall", stall_o, exp_stall);
        checkOutput("err", err_o, m_err);
        checkOutput("rdata", rdata_o, m_rdata);
        if (m_active) begin
            checkOutput("mem_we", mem_we_o, m_we);
            checkOutput("mem_addr", mem_addr_o, m_addr);
            checkOutput("mem_wdata", mem_wdata_o, m_wdata);
        end
    end

    // Presents one access (called just after a falling edge) and follows it to
    // its DONE/ABORT cycle, acking on the ack_at-th request cycle (0 = never).
    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdat,
                                 input int ack_at, input bit keep,
                                 output int req_cnt, output int stall_cnt, output int wb_cnt,
                                 output logic we_seen, output logic [31:0] addr_seen,
                                 output logic [31:0] wdata_seen);
        bit   ended;
        logic prev_req;
        req_cnt = 0; stall_cnt = 0; wb_cnt = 0; ended = 0; prev_req = 0;
        we_seen = 0; addr_seen = 0; wdata_seen = 0;
        mem_read_i = rd; mem_write_i = wr; addr_i = addr; wdata_i = wdata;
        mem_rdata_i = rdat; mem_ack_i = 0;
        for (int cyc = 0; cyc < TIMEOUT + 8 && !ended; cyc++) begin
            @(posedge clk);
            if (stall_o) stall_cnt++;
            if (wb_valid_o) wb_cnt++;
            if (mem_req_o) begin
                req_cnt++;
                if (req_cnt == 1) begin
                    we_seen = mem_we_o; addr_seen = mem_addr_o; wdata_seen = mem_wdata_o;
                end
                if (req_cnt == ack_at) mem_ack_i = 1;
            end else if (prev_req || (cyc == 0 && !stall_o)) begin
                ended = 1;
            end
            prev_req = mem_req_o;
            @(negedge clk); #2;
            mem_ack_i = 0;
        end
        if (!keep) begin
            mem_read_i = 0; mem_write_i = 0;
        end
        checkOutput("access_ended", ended, 1);
    endtask

    task automatic pulseClear();
        err_clr_i = 1;
        @(negedge clk); #2;
        err_clr_i = 0;
    endtask

    // Watchdog so a stuck run still ends with a report.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          rq, st, wb;
        logic        we;
        logic [31:0] ad, wd;
        reset = 1; mem_read_i = 0; mem_write_i = 0; addr_i = 0; wdata_i = 0;
        mem_ack_i = 0; mem_rdata_i = 0; err_clr_i = 0;
        #1 reset = 0;
        #20;
        checkOutput("reset_req", mem_req_o, 0);
        checkOutput("reset_addr", mem_addr_o, 0);
        checkOutput("reset_err", err_o, 0);
        @(negedge clk); #2;
        reset = 1;

        // Load with ack on the third busy cycle.
        applyStimulus(1, 0, 32'h100, 32'h0, 32'hDEADBEEF, 3, 0, rq, st, wb, we, ad, wd);
        checkOutput("read_req_cycles", rq, 3);
        checkOutput("read_stall_cycles", st, 4);
        checkOutput("read_wb_pulses", wb, 1);
        checkOutput("read_we", we, 0);
        checkOutput("read_rdata", rdata_o, 32'hDEADBEEF);

        // Store with ack on the first busy cycle; load data must not change.
        applyStimulus(0, 1, 32'h204, 32'h12345678, 32'hBADBAD00, 1, 0, rq, st, wb, we, ad, wd);
        checkOutput("write_req_cycles", rq, 1);
        checkOutput("write_we", we, 1);
        checkOutput("write_addr", ad, 32'h204);
        checkOutput("write_wdata", wd, 32'h12345678);
        checkOutput("write_wb_pulses", wb, 1);
        checkOutput("write_rdata_kept", rdata_o, 32'hDEADBEEF);

        // Both flags set is a store.
        applyStimulus(1, 1, 32'h208, 32'hCAFEF00D, 32'h11111111, 2, 0, rq, st, wb, we, ad, wd);
        checkOutput("both_we", we, 1);
        checkOutput("both_rdata_kept", rdata_o, 32'hDEADBEEF);

        // Timeout with no ack.
        applyStimulus(1, 0, 32'h300, 32'h0, 32'h0, 0, 0, rq, st, wb, we, ad, wd);
        checkOutput("timeout_req_cycles", rq, TIMEOUT);
        checkOutput("timeout_wb_pulses", wb, 0);
        checkOutput("timeout_err", err_o, 1);
        pulseClear();
        checkOutput("timeout_err_cleared", err_o, 0);

        // Ack on the last allowed cycle still succeeds.
        applyStimulus(1, 0, 32'h304, 32'h0, 32'h0BADF00D, TIMEOUT, 0, rq, st, wb, we, ad, wd);
        checkOutput("lastack_req_cycles", rq, TIMEOUT);
        checkOutput("lastack_wb_pulses", wb, 1);
        checkOutput("lastack_err", err_o, 0);
        checkOutput("lastack_rdata", rdata_o, 32'h0BADF00D);

        // Misaligned load: error, no request, no stall.
        applyStimulus(1, 0, 32'h102, 32'h0, 32'h0, 1, 0, rq, st, wb, we, ad, wd);
        checkOutput("misaligned_req_cycles", rq, 0);
        checkOutput("misaligned_stall_cycles", st, 0);
        checkOutput("misaligned_err", err_o, 1);
        pulseClear();
        checkOutput("misaligned_err_cleared", err_o, 0);

        // Misaligned access together with a clear keeps the error set.
        err_clr_i = 1;
        applyStimulus(0, 1, 32'h401, 32'h0, 32'h0, 1, 0, rq, st, wb, we, ad, wd);
        err_clr_i = 0;
        checkOutput("clear_collision_err", err_o, 1);
        pulseClear();

        // Stray acks while idle are ignored.
        mem_ack_i = 1; mem_rdata_i = 32'h55555555;
        repeat (3) @(negedge clk);
        #2 mem_ack_i = 0;
        checkOutput("idle_ack_rdata", rdata_o, 32'h0BADF00D);

        // Two loads back to back: the second starts in the IDLE cycle after DONE.
        applyStimulus(1, 0, 32'h500, 32'h0, 32'hAAAA0001, 2, 1, rq, st, wb, we, ad, wd);
        checkOutput("b2b_first_req", rq, 2);
        applyStimulus(1, 0, 32'h504, 32'h0, 32'hAAAA0002, 1, 0, rq, st, wb, we, ad, wd);
        checkOutput("b2b_second_req", rq, 1);
        checkOutput("b2b_second_stall", st, 2);
        checkOutput("b2b_second_addr", ad, 32'h504);
        checkOutput("b2b_rdata", rdata_o, 32'hAAAA0002);

        // Reset during BUSY drops the request at once and discards the access.
        mem_read_i = 1; addr_i = 32'h600; mem_ack_i = 0;
        repeat (3) @(posedge clk);
        #2 reset = 0;
        #1;
        checkOutput("midreset_req", mem_req_o, 0);
        checkOutput("midreset_stall", stall_o, 0);
        checkOutput("midreset_addr", mem_addr_o, 0);
        checkOutput("midreset_rdata", rdata_o, 0);
        mem_read_i = 0; addr_i = 0;
        @(negedge clk); #2;
        reset = 1;
        wb = 0; rq = 0;
        repeat (4) begin
            @(posedge clk);
            if (wb_valid_o) wb++;
            if (mem_req_o) rq++;
        end
        checkOutput("midreset_no_wb", wb, 0);
        checkOutput("midreset_no_req", rq, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_access_sequencer.md
MEM_ACCESS_SEQUENCER -- requirements
Module: mem_access_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum number of BUSY cycles allowed for an access before it is aborted.
REQ-002 clk  input  1  pipeline clock; all state updates occur on the falling edge, matching the pipeline registers.
REQ-003 reset  input  1  reset, asynchronous, active-low.
REQ-004 mem_read_i  input  1  load flag from the EX/MEM register output.
REQ-005 mem_write_i  input  1  store flag from the EX/MEM register output.
REQ-006 addr_i  input  32  ALU result (address) from EX/MEM.
REQ-007 wdata_i  input  32  store data (R2) from EX/MEM.
REQ-008 mem_ack_i  input  1  data memory completion strobe.
REQ-009 mem_rdata_i  input  32  data memory read data; valid while mem_ack_i=1.
REQ-010 err_clr_i  input  1  clears err_o.
REQ-011 mem_req_o  output  1  memory request, registered.
REQ-012 mem_we_o  output  1  1=write, 0=read; valid while mem_req_o=1.
REQ-013 mem_addr_o  output  32  latched address.
REQ-014 mem_wdata_o  output  32  latched store data.
REQ-015 rdata_o  output  32  captured load data.
REQ-016 stall_o  output  1  when 1, forces pipeline register enables to 0.
REQ-017 wb_valid_o  output  1  one-cycle pulse marking a completed access.
REQ-018 err_o  output  1  sticky error flag (timeout or misaligned access).

Function
REQ-019 The FSM SHALL have four states: IDLE, BUSY, DONE and ABORT.
REQ-020 An access exists in IDLE when mem_read_i|mem_write_i=1; if both flags are 1, the access SHALL be a write.
REQ-021 IDLE, aligned access (addr_i[1:0]=00): on the edge, latch addr_i, wdata_i and we (write flag), clear the cycle counter, go to BUSY.
REQ-022 IDLE, misaligned access: set err_o, issue no request, stay in IDLE, stall_o=0.
REQ-023 stall_o SHALL equal (IDLE & aligned access) | BUSY, combinationally, so EX/MEM holds from the first cycle of an access.
REQ-024 BUSY: mem_req_o=1 and the counter increments each cycle.
REQ-025 BUSY, mem_ack_i=1 sampled: capture mem_rdata_i into rdata_o if a read (rdata_o unchanged for writes), go to DONE.
REQ-026 BUSY, no ack, counter = TIMEOUT-1: go to ABORT; an ack on the TIMEOUT-th cycle SHALL count as success.
REQ-027 DONE lasts one cycle: wb_valid_o=1, stall_o=0, mem_req_o=0, next state IDLE unconditionally.
REQ-028 DONE SHALL NOT start a new access, because EX/MEM still holds the completed access during that cycle.
REQ-029 ABORT lasts one cycle: set err_o, wb_valid_o=0, stall_o=0, mem_req_o=0, next state IDLE.
REQ-030 Latency: access accepted in cycle N, mem_req_o=1 from N+1; ack sampled in cycle M gives wb_valid_o and valid rdata_o in M+1.
REQ-031 mem_ack_i outside BUSY SHALL be ignored.
REQ-032 err_o SHALL remain set until err_clr_i=1; a simultaneous error event and err_clr_i SHALL leave err_o=1.
REQ-033 mem_addr_o, mem_wdata_o and mem_we_o SHALL be stable throughout BUSY.

Reset
REQ-034 reset=0 SHALL immediately force state=IDLE and clear every output and register: mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, rdata_o, wb_valid_o, err_o and the counter.
REQ-035 reset asserted during BUSY SHALL drop mem_req_o without waiting for a clock edge and discard the access.
REQ-036 After reset release, the first falling edge SHALL evaluate from IDLE.

Verification
REQ-037 Read: addr=0x100, mem_read=1, ack on 3rd BUSY cycle with rdata=0xDEADBEEF -> req high 3 cycles, stall high 4 cycles, then wb_valid pulse with rdata_o=0xDEADBEEF.
REQ-038 Write: addr=0x204, wdata=0x12345678, ack on 1st BUSY cycle -> mem_we_o=1, mem_addr_o=0x204, mem_wdata_o=0x12345678, wb_valid 1 cycle, rdata_o unchanged.
REQ-039 Timeout: TIMEOUT=16, no ack -> req high 16 cycles, ABORT, err_o=1, wb_valid_o stays 0; ack exactly on cycle 16 -> DONE, err_o=0.
REQ-040 Misaligned: mem_read=1, addr=0x102 -> err_o=1, mem_req_o never asserted, stall_o=0; err_clr_i pulse -> err_o=0.
REQ-041 Back-to-back: two consecutive loads in EX/MEM -> second access starts in the IDLE cycle after DONE; each access issues exactly one request.
REQ-042 Reset mid-BUSY: reset=0 two cycles after request -> mem_req_o falls asynchronously, all outputs 0, no wb_valid pulse after release.
